// File: rtl/input_skew_feeder.sv
// Reads NUM_ROWS row FIFOs with a one-cycle-per-row start skew and forwards the
// returned words to a systolic array as diagonally aligned operand wavefronts.
module input_skew_feeder #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_ROWS   = 4,
  parameter int unsigned FIFO_SIZE  = 16,
  parameter int unsigned CNT_WIDTH  = 6
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic                               abort,
  input  logic [NUM_ROWS*DATA_WIDTH*2-1:0]   fifo_data_in,
  output logic [NUM_ROWS-1:0]                fifo_rd_en,
  output logic [NUM_ROWS-1:0]                fifo_rd_clr,
  output logic [NUM_ROWS*DATA_WIDTH*2-1:0]   pe_data_out,
  output logic [NUM_ROWS-1:0]                pe_valid,
  output logic                               busy,
  output logic                               done
);

  localparam int unsigned WORD = 2 * DATA_WIDTH;
  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(FIFO_SIZE + NUM_ROWS - 2);

  typedef enum logic [2:0] {IDLE, CLEAR, FEED, FLUSH, DONE} state_t;

  state_t               state;
  logic [CNT_WIDTH-1:0] cnt;

  // Row r reads during feed counts r .. r+FIFO_SIZE-1.
  function automatic logic [NUM_ROWS-1:0] rows_enabled(input logic [CNT_WIDTH-1:0] c);
    logic [NUM_ROWS-1:0] m;
    int unsigned         ci;
    m  = '0;
    ci = 32'(c);
    for (int unsigned r = 0; r < NUM_ROWS; r++) begin
      m[r] = (ci >= r) && (ci < r + FIFO_SIZE);
    end
    return m;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      fifo_rd_en  <= '0;
      fifo_rd_clr <= '0;
      pe_valid    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      pe_valid <= fifo_rd_en;
      if (state != IDLE && abort) begin
        state       <= IDLE;
        cnt         <= '0;
        fifo_rd_en  <= '0;
        fifo_rd_clr <= '0;
        pe_valid    <= '0;
        busy        <= 1'b0;
        done        <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            done <= 1'b0;
            if (start) begin
              state       <= CLEAR;
              fifo_rd_clr <= '1;
              busy        <= 1'b1;
            end
          end
          CLEAR: begin
            state       <= FEED;
            fifo_rd_clr <= '0;
            cnt         <= '0;
            fifo_rd_en  <= rows_enabled('0);
          end
          FEED: begin
            // Enables are registered, so they are computed for the upcoming count.
            if (cnt == LAST_CNT) begin
              state      <= FLUSH;
              fifo_rd_en <= '0;
            end else begin
              cnt        <= cnt + CNT_WIDTH'(1);
              fifo_rd_en <= rows_enabled(cnt + CNT_WIDTH'(1));
            end
          end
          FLUSH: begin
            state <= DONE;
            done  <= 1'b1;
          end
          DONE: begin
            state <= IDLE;
            done  <= 1'b0;
            busy  <= 1'b0;
            cnt   <= '0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_comb begin
    pe_data_out = '0;
    for (int unsigned r = 0; r < NUM_ROWS; r++) begin
      if (pe_valid[r]) pe_data_out[r*WORD +: WORD] = fifo_data_in[r*WORD +: WORD];
    end
  end

endmodule
